// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, access size
// encodings, the unsigned-load flag position and a byte-mask helper.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // req_size bit that selects zero-extension on loads
    localparam int SZ_UNSIGNED_BIT = 2;

    // Contiguous byte mask for an access, unshifted. Encoding 11 acts as word.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles for the load/store unit.
// lsu_req_if: core request/response (master = core, slave = unit).
// lsu_mem_if: word-aligned memory beats (master = unit, slave = memory).
interface lsu_req_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_size;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: byte-lane steering for one access (combinational).
// Ports: i_off/i_size/i_wdata in; o_be0/o_be1/o_wd0/o_wd1/o_split for beats;
// i_b0/i_b1 beat read words in; o_rdata merged and extended load result.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_b0,
    input  logic [31:0] i_b1,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wd0,
    output logic [31:0] o_wd1,
    output logic        o_split,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_be;
    logic [63:0] w_wd;
    logic [63:0] w_rd;
    logic [31:0] w_raw;
    logic        w_sgn;

    // Shift across an 8-lane window: the upper half spills into beat 1.
    assign w_be    = {4'b0000, size_mask(i_size[1:0])} << i_off;
    assign w_wd    = {32'd0, i_wdata} << {i_off, 3'b000};
    assign o_be0   = w_be[3:0];
    assign o_be1   = w_be[7:4];
    assign o_wd0   = w_wd[31:0];
    assign o_wd1   = w_wd[63:32];
    assign o_split = |w_be[7:4];

    // Beat 1 sits above beat 0, so one right shift merges both words.
    assign w_rd  = {i_b1, i_b0} >> {i_off, 3'b000};
    assign w_raw = w_rd[31:0];
    assign w_sgn = ~i_size[SZ_UNSIGNED_BIT];

    always_comb begin
        o_rdata = w_raw;
        case (i_size[1:0])
            SZ_BYTE: o_rdata = {{24{w_sgn & w_raw[7]}}, w_raw[7:0]};
            SZ_HALF: o_rdata = {{16{w_sgn & w_raw[15]}}, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: splits misaligned core accesses into word-aligned beats.
// Ports: clk, rst (async, active-high); core (lsu_req_if.slave);
// mem (lsu_mem_if.master). One beat outstanding at a time.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  core,
    lsu_mem_if.master mem
);
    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_size;
    logic [31:0]       r_b0;
    logic [31:0]       r_b1;

    logic [ADDR_W-1:0] w_base;
    logic [3:0]        w_be0;
    logic [3:0]        w_be1;
    logic [31:0]       w_wd0;
    logic [31:0]       w_wd1;
    logic              w_split;
    logic [31:0]       w_rdata;
    logic              w_accept;

    assign w_base   = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_accept = core.req_valid & (r_state == S_IDLE);

    lsu_lane_align u_align (
        .i_off   (r_addr[1:0]),
        .i_size  (r_size),
        .i_wdata (r_wdata),
        .i_b0    (r_b0),
        .i_b1    (r_b1),
        .o_be0   (w_be0),
        .o_be1   (w_be1),
        .o_wd0   (w_wd0),
        .o_wd1   (w_wd1),
        .o_split (w_split),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= core.req_we;
                r_addr  <= core.req_addr;
                r_wdata <= core.req_wdata;
                r_size  <= core.req_size;
            end
            if (r_state == S_WAIT0 && mem.mem_rvalid) begin
                r_b0 <= mem.mem_rdata;
            end
            if (r_state == S_WAIT1 && mem.mem_rvalid) begin
                r_b1 <= mem.mem_rdata;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        core.req_ready = 1'b0;
        core.rsp_valid = 1'b0;
        core.rsp_rdata = '0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_be     = '0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                core.req_ready = 1'b1;
                if (core.req_valid) w_next = S_REQ0;
            end
            S_REQ0: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = r_we;
                mem.mem_be    = w_be0;
                mem.mem_addr  = w_base;
                mem.mem_wdata = w_wd0;
                if (mem.mem_gnt) w_next = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem.mem_rvalid) w_next = w_split ? S_REQ1 : S_RESP;
            end
            S_REQ1: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = r_we;
                mem.mem_be    = w_be1;
                mem.mem_addr  = w_base + ADDR_W'(4);
                mem.mem_wdata = w_wd1;
                if (mem.mem_gnt) w_next = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem.mem_rvalid) w_next = S_RESP;
            end
            S_RESP: begin
                core.rsp_valid = 1'b1;
                core.rsp_rdata = r_we ? 32'd0 : w_rdata;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of core and memory address ports.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core presents a load/store.
REQ-005 req_ready  output  1  unit accepts a request; transfer when req_valid & req_ready.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  ADDR_W  byte address, any alignment.
REQ-008 req_wdata  input  32  store data, right-justified.
REQ-009 req_size  input  3  [1:0] 00 byte, 01 half, 10 word; [2] 1 = unsigned load.
REQ-010 rsp_valid  output  1  one-cycle pulse: access complete.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores.
REQ-012 mem_req  output  1  word-aligned memory beat request.
REQ-013 mem_gnt  input  1  memory accepts beat when mem_req & mem_gnt.
REQ-014 mem_addr  output  ADDR_W  word address, bits [1:0] = 0.
REQ-015 mem_we / mem_be / mem_wdata  output  1 / 4 / 32  beat write flag, byte lanes, lane-positioned data.
REQ-016 mem_rvalid / mem_rdata  input  1 / 32  beat completion (loads and stores), word-aligned data.

Function
REQ-017 The unit SHALL implement states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; acceptance SHALL register we, addr, wdata, size and move to REQ0.
REQ-019 Offset o = addr[1:0], size bytes n ∈ {1,2,4}; access SHALL be split when o + n > 4.
REQ-020 Beat 0: mem_addr = {addr[ADDR_W-1:2],00}, mem_be = ((1<<n)-1) << o truncated to 4 bits, mem_wdata = wdata << 8·o.
REQ-021 Beat 1 (split only): mem_addr = beat-0 address + 4 (wraps modulo 2^ADDR_W), mem_be = ((1<<n)-1) >> (4-o), mem_wdata = wdata >> 8·(4-o).
REQ-022 mem_req SHALL be 1 exactly in REQ0/REQ1 and held, with stable address/be/data, until mem_gnt.
REQ-023 REQx SHALL go to WAITx on grant; WAIT0 SHALL go to REQ1 (split) or RESP on mem_rvalid; WAIT1 SHALL go to RESP on mem_rvalid.
REQ-024 mem_rvalid outside WAIT0/WAIT1 SHALL be ignored; at most one beat outstanding.
REQ-025 Load merge: beat-0 bytes SHALL be taken from lanes o..3 into result bytes 0..; beat-1 lanes 0.. SHALL fill the remaining bytes.
REQ-026 Extension: byte/half SHALL be sign-extended when req_size[2]=0, zero-extended when 1; word unaffected.
REQ-027 RESP SHALL assert rsp_valid for one cycle and return to IDLE; no new request accepted in RESP.
REQ-028 Minimum latency (gnt same cycle, rvalid next cycle): aligned = 4 cycles from accept edge to rsp_valid, split = 6.
REQ-029 req_size[1:0] = 11 SHALL be treated as word.

Reset
REQ-030 rst SHALL force IDLE immediately; req_ready=1, rsp_valid=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset mid-access SHALL abandon the access with no rsp_valid; a later stray mem_rvalid SHALL be ignored.

Structure
REQ-032 Shared package SHALL hold state enum, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and unsigned-bit index.
REQ-033 One sub-module lsu_lane_align SHALL compute per-beat be/wdata and load merge/extension combinationally.

Verification
REQ-034 Load word addr 0x100, mem_rdata 0xDEADBEEF -> one beat be=1111, rsp_rdata 0xDEADBEEF 4 cycles after accept.
REQ-035 Signed byte load addr 0x103, rdata 0x80FFFFFF -> be=1000, rsp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Store half 0xABCD at 0x203 -> beat0 addr 0x200 be=1000 wdata[31:24]=0xCD; beat1 addr 0x204 be=0001 wdata[7:0]=0xAB; rsp_rdata 0.
REQ-037 Load word 0x302, beat rdata 0x1122_3344 then 0x5566_7788 -> rsp_rdata 0x7788_1122.
REQ-038 mem_gnt held 0 for 5 cycles -> mem_req and beat fields stable throughout, req_ready 0.
REQ-039 rst pulse while in WAIT0, then mem_rvalid -> outputs at reset values, no rsp_valid, next request served normally.
